// File: rtl/count_monitor.sv
// count_monitor: watches a mod-N up/down counter, locks onto its direction,
// and reports wraps, sequence errors, direction flips and out-of-range faults.
module count_monitor #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cnt_in,
  input  logic         sample_en,
  output logic         locked,
  output logic         dir_up,
  output logic         wrap_pulse,
  output logic         err_pulse,
  output logic         dir_flip,
  output logic         fault,
  output logic [7:0]   wrap_count,
  output logic [7:0]   err_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    LOCK_UP = 3'd2,
    LOCK_DN = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [W-1:0] TOP = W'(N - 1);

  state_t       state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic         locked_q, locked_d;
  logic         dir_up_q, dir_up_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic         flip_q, flip_d;
  logic         fault_q, fault_d;
  logic [7:0]   wrap_cnt_q, wrap_cnt_d;
  logic [7:0]   err_cnt_q, err_cnt_d;

  logic [W-1:0] inc_prev;
  logic [W-1:0] dec_prev;
  logic [31:0]  cnt_ext;

  // Modulo-N neighbours of the last sampled value.
  always_comb begin
    inc_prev = (prev_q == TOP) ? '0 : prev_q + W'(1);
    dec_prev = (prev_q == '0) ? TOP : prev_q - W'(1);
    cnt_ext  = 32'(cnt_in);
  end

  // Next-state and registered-output computation; up match is checked first
  // everywhere so that N==2 (inc==dec) resolves to the up interpretation.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    flip_d     = 1'b0;
    fault_d    = fault_q;
    wrap_cnt_d = wrap_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (sample_en && (state_q != FAULT)) begin
      if (cnt_ext >= 32'(N)) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else begin
        prev_d = cnt_in;
        case (state_q)
          IDLE: state_d = SYNC;
          SYNC: begin
            if (cnt_in == inc_prev)      state_d = LOCK_UP;
            else if (cnt_in == dec_prev) state_d = LOCK_DN;
          end
          LOCK_UP: begin
            if (cnt_in == inc_prev) begin
              wrap_d = (prev_q == TOP);
            end else if (cnt_in == prev_q) begin
              state_d = LOCK_UP;
            end else if (cnt_in == dec_prev) begin
              state_d = LOCK_DN;
              flip_d  = 1'b1;
            end else begin
              state_d = SYNC;
              err_d   = 1'b1;
            end
          end
          LOCK_DN: begin
            if (cnt_in == inc_prev) begin
              state_d = LOCK_UP;
              flip_d  = 1'b1;
            end else if (cnt_in == prev_q) begin
              state_d = LOCK_DN;
            end else if (cnt_in == dec_prev) begin
              wrap_d = (prev_q == '0);
            end else begin
              state_d = SYNC;
              err_d   = 1'b1;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end

    if (wrap_d) wrap_cnt_d = wrap_cnt_q + 8'd1;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    locked_d = (state_d == LOCK_UP) || (state_d == LOCK_DN);
    dir_up_d = (state_d == LOCK_UP);
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      locked_q   <= 1'b0;
      dir_up_q   <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      flip_q     <= 1'b0;
      fault_q    <= 1'b0;
      wrap_cnt_q <= 8'd0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      locked_q   <= locked_d;
      dir_up_q   <= dir_up_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      flip_q     <= flip_d;
      fault_q    <= fault_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign dir_up     = dir_up_q;
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_q;
  assign dir_flip   = flip_q;
  assign fault      = fault_q;
  assign wrap_count = wrap_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter N, default 10: modulus of the observed counter, legal range 2..16.
REQ-002 Parameter W, default 4: width of the observed count bus.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
REQ-005 cnt_in  input  W  count value driven by the observed mod-N up/down counter.
REQ-006 sample_en  input  1  cnt_in is sampled on a rising edge only when high.
REQ-007 locked  output  1  high while direction is established (LOCK_UP or LOCK_DN).
REQ-008 dir_up  output  1  1 = counting up, 0 = counting down; valid only when locked.
REQ-009 wrap_pulse  output  1  one-cycle pulse on a legal modulus wrap.
REQ-010 err_pulse  output  1  one-cycle pulse on a sequence mismatch.
REQ-011 dir_flip  output  1  one-cycle pulse on a legal direction reversal.
REQ-012 fault  output  1  sticky; cnt_in was >= N on a sample.
REQ-013 wrap_count  output  8  number of wraps, modulo 256.
REQ-014 err_count  output  8  number of mismatches, saturating at 255.

Function
REQ-015 Notation: inc(x) = (x==N-1) ? 0 : x+1; dec(x) = (x==0) ? N-1 : x-1; prev = last sampled value (internal W-bit register).
REQ-016 FSM states: IDLE, SYNC, LOCK_UP, LOCK_DN, FAULT; all outputs registered, updated on the edge that samples cnt_in (latency 1 clock).
REQ-017 Cycles with sample_en=0: no state, prev, or counter change; all pulses low.
REQ-018 Any state except FAULT, sampled cnt_in >= N: go to FAULT; set fault; no other pulse; no counter update.
REQ-019 FAULT: absorbing until reset; locked=0; all pulses 0.
REQ-020 IDLE, legal sample: prev <= cnt_in; go to SYNC.
REQ-021 SYNC, cnt_in==inc(prev): go to LOCK_UP. Else cnt_in==dec(prev): go to LOCK_DN. Otherwise stay in SYNC. No error in any case; prev <= cnt_in.
REQ-022 When N==2, inc==dec; the up interpretation SHALL take priority everywhere.
REQ-023 LOCK_UP: cnt_in==inc(prev) is a legal step. cnt_in==prev is a hold (no pulse). cnt_in==dec(prev) goes to LOCK_DN with dir_flip. Any other value goes to SYNC with err_pulse.
REQ-024 LOCK_DN: mirror of REQ-023 with inc/dec swapped; dir_flip on reversal to LOCK_UP.
REQ-025 wrap_pulse and wrap_count+1 on these transitions only:
- LOCK_UP legal step with prev==N-1, cnt_in==0;
- LOCK_DN legal step with prev==0, cnt_in==N-1;
- neither on SYNC exit nor on a reversal.
REQ-026 err_pulse sets err_count+1, saturating at 255; a mismatch in SYNC is not an error.
REQ-027 In every locked or SYNC state, prev <= cnt_in on each legal sample.
REQ-028 locked=1 exactly in LOCK_UP/LOCK_DN; dir_up=1 in LOCK_UP, 0 otherwise.

Reset
REQ-029 reset high SHALL immediately (asynchronously) force:
- state=IDLE, prev=0;
- all outputs 0, including fault, wrap_count and err_count.
REQ-030 Reset asserted mid-sequence discards all history; the first sample after release is treated as in IDLE.
REQ-031 Release of reset is synchronous to clk; no sample is taken on the release edge if reset is still high at that edge.

Verification (N=10, clk period 50 ns, reset high for first 100 ns)
REQ-032 Up run: sample 3,4,5...9,0,1 -> locked=1, dir_up=1 after the 2nd sample; one wrap_pulse on the 0 sample; wrap_count=1; err_count=0.
REQ-033 Down run with reversal: sample 2,1,0,9,8,9,0 ->
- LOCK_DN after 1;
- wrap on 9 (wrap_count=1);
- dir_flip on the second 9, then dir_up=1;
- wrap on 0 (wrap_count=2).
REQ-034 Mismatch: locked up at 5, sample 8 -> err_pulse=1, locked=0, err_count=1; then sample 9 -> LOCK_UP again, no error.
REQ-035 Hold and gating: locked up at 4; samples 4,4, then sample_en=0 for 5 cycles with cnt_in=7; then sample 5 -> no pulses during that sequence, still LOCK_UP.
REQ-036 Fault and reset: sample cnt_in=12 -> fault=1, locked=0; further legal samples are ignored; assert reset mid-cycle -> all outputs 0 without waiting for an edge.
REQ-037 Saturation: force 260 mismatches -> err_count holds at 255.
